// File: rtl/ifmap_window_scanner.sv
// ifmap_window_scanner: walks every window origin of a convolution job, issues ifmap reads
// and forwards masked, coordinate-tagged windows. Define IFMAP_SCAN_PREFETCH_EN for a 2-deep prefetch.
module ifmap_window_scanner #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [5:0]        cfg_conv_size,
    input  logic [1:0]        cfg_fil_size,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DATA_W-1:0] win_data,
    output logic [5:0]        win_y,
    output logic [5:0]        win_x,
    output logic              win_ts,
    output logic              win_last,
    output logic              done
);

`ifdef IFMAP_SCAN_PREFETCH_EN
    localparam logic [1:0] CAP = 2'd2;
`else
    localparam logic [1:0] CAP = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [5:0]        y;
        logic [5:0]        x;
        logic              ts;
        logic              last;
    } win_entry_t;

    function automatic logic [DATA_W-1:0] window_mask(input logic [1:0] code);
        logic [DATA_W-1:0] one_v;
        one_v = {{(DATA_W-1){1'b0}}, 1'b1};
        case (code)
            2'b00:   window_mask = (one_v << 3'd4) - one_v;
            2'b01:   window_mask = (one_v << 4'd9) - one_v;
            2'b10:   window_mask = (one_v << 5'd16) - one_v;
            2'b11:   window_mask = {DATA_W{1'b1}};
            default: window_mask = {DATA_W{1'b0}};
        endcase
    endfunction

    // Scan order is ts outer, then y, then x; returns the position following {y, x, ts}.
    function automatic logic [12:0] next_pos(input logic [5:0] y, input logic [5:0] x,
                                             input logic ts, input logic [5:0] n);
        if (x != n - 6'd1) begin
            next_pos = {y, x + 6'd1, ts};
        end else if (y != n - 6'd1) begin
            next_pos = {y + 6'd1, 6'd0, ts};
        end else begin
            next_pos = {6'd0, 6'd0, ~ts};
        end
    endfunction

    state_t            state_r, state_s;
    logic [5:0]        n_r;
    logic [1:0]        fil_r;
    logic [5:0]        y_r, x_r, ry_r, rx_r;
    logic              ts_r, rts_r;
    logic [1:0]        cnt_r, cnt_next_s, occ_next_s;
    logic              req_valid_r, rsp_ready_r, win_valid_r;
    logic              cfg_fire_s, req_fire_s, rsp_fire_s, win_fire_s, last_req_s;
    logic              out_free_s, win_valid_next_s;
    win_entry_t        rsp_entry_s, win_entry_r;
`ifdef IFMAP_SCAN_PREFETCH_EN
    logic              skid_valid_r, skid_valid_next_s;
    win_entry_t        skid_entry_r;
`endif

    assign req_valid = req_valid_r;
    assign req_addr  = {y_r, x_r, ts_r};
    assign rsp_ready = rsp_ready_r;
    assign win_valid = win_valid_r;
    assign win_data  = win_entry_r.data;
    assign win_y     = win_entry_r.y;
    assign win_x     = win_entry_r.x;
    assign win_ts    = win_entry_r.ts;
    assign win_last  = win_entry_r.last;

    // Handshake decode, credit count and masked response entry.
    always_comb begin
        cfg_fire_s = cfg_valid && (state_r == IDLE);
        req_fire_s = req_valid_r && req_ready;
        rsp_fire_s = rsp_valid && rsp_ready_r;
        win_fire_s = win_valid_r && win_ready;
        last_req_s = ts_r && (y_r == n_r - 6'd1) && (x_r == n_r - 6'd1);
        // Responses come back in request order, so a second walker reproduces each tag.
        rsp_entry_s.data = rsp_data & window_mask(fil_r);
        rsp_entry_s.y    = ry_r;
        rsp_entry_s.x    = rx_r;
        rsp_entry_s.ts   = rts_r;
        rsp_entry_s.last = rts_r && (ry_r == n_r - 6'd1) && (rx_r == n_r - 6'd1);
        if (req_fire_s && !win_fire_s) begin
            cnt_next_s = cnt_r + 2'd1;
        end else if (!req_fire_s && win_fire_s) begin
            cnt_next_s = cnt_r - 2'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Occupancy of the output register (plus skid entry when prefetching) for the next cycle.
    always_comb begin
        out_free_s = !win_valid_r || win_fire_s;
`ifdef IFMAP_SCAN_PREFETCH_EN
        if (out_free_s) begin
            win_valid_next_s  = skid_valid_r || rsp_fire_s;
            skid_valid_next_s = skid_valid_r && rsp_fire_s;
        end else begin
            win_valid_next_s  = 1'b1;
            skid_valid_next_s = skid_valid_r || rsp_fire_s;
        end
        occ_next_s = {1'b0, win_valid_next_s} + {1'b0, skid_valid_next_s};
`else
        if (out_free_s) begin
            win_valid_next_s = rsp_fire_s;
        end else begin
            win_valid_next_s = 1'b1;
        end
        occ_next_s = {1'b0, win_valid_next_s};
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_fire_s) begin
                    state_s = (cfg_conv_size == 6'd0) ? FIN : SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (req_fire_s && last_req_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = SCAN;
                end
            end
            DRAIN: begin
                if (win_fire_s && win_entry_r.last) begin
                    state_s = FIN;
                end else begin
                    state_s = DRAIN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        cfg_ready = 1'b0;
        done      = 1'b0;
        case (state_r)
            IDLE:    cfg_ready = 1'b1;
            FIN:     done      = 1'b1;
            default: begin
                cfg_ready = 1'b0;
                done      = 1'b0;
            end
        endcase
    end

    // Job config, request walker, credit count and request valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r         <= 6'd0;
            fil_r       <= 2'd0;
            y_r         <= 6'd0;
            x_r         <= 6'd0;
            ts_r        <= 1'b0;
            cnt_r       <= 2'd0;
            req_valid_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_next_s;
            req_valid_r <= (state_s == SCAN) && (cnt_next_s < CAP);
            if (cfg_fire_s) begin
                n_r   <= cfg_conv_size;
                fil_r <= cfg_fil_size;
                y_r   <= 6'd0;
                x_r   <= 6'd0;
                ts_r  <= 1'b0;
            end else if (req_fire_s) begin
                {y_r, x_r, ts_r} <= next_pos(y_r, x_r, ts_r, n_r);
            end
        end
    end

    // Response tag walker and response ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ry_r        <= 6'd0;
            rx_r        <= 6'd0;
            rts_r       <= 1'b0;
            rsp_ready_r <= 1'b0;
        end else begin
            rsp_ready_r <= ((state_s == SCAN) || (state_s == DRAIN)) && (occ_next_s < CAP);
            if (cfg_fire_s) begin
                ry_r  <= 6'd0;
                rx_r  <= 6'd0;
                rts_r <= 1'b0;
            end else if (rsp_fire_s) begin
                {ry_r, rx_r, rts_r} <= next_pos(ry_r, rx_r, rts_r, n_r);
            end
        end
    end

    // Output window register, backed by a skid entry when prefetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_r  <= 1'b0;
            win_entry_r  <= '0;
`ifdef IFMAP_SCAN_PREFETCH_EN
            skid_valid_r <= 1'b0;
            skid_entry_r <= '0;
`endif
        end else begin
            win_valid_r <= win_valid_next_s;
`ifdef IFMAP_SCAN_PREFETCH_EN
            skid_valid_r <= skid_valid_next_s;
            if (out_free_s) begin
                if (skid_valid_r) begin
                    win_entry_r <= skid_entry_r;
                    if (rsp_fire_s) begin
                        skid_entry_r <= rsp_entry_s;
                    end
                end else if (rsp_fire_s) begin
                    win_entry_r <= rsp_entry_s;
                end
            end else if (rsp_fire_s) begin
                skid_entry_r <= rsp_entry_s;
            end
`else
            if (out_free_s && rsp_fire_s) begin
                win_entry_r <= rsp_entry_s;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ifmap_window_scanner.sv
// Scoreboard bench for ifmap_window_scanner: directed jobs against a zero-latency memory model,
// expected requests/windows queued at stimulus time and checked by an independent monitor.
module tb_ifmap_window_scanner;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 25;
`ifdef IFMAP_SCAN_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [24:0] data;
        logic [5:0]  y;
        logic [5:0]  x;
        logic        ts;
        logic        last;
    } win_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [5:0]        cfg_conv_size = 6'd0;
    logic [1:0]        cfg_fil_size = 2'd0;
    logic              req_valid;
    logic              req_ready = 1'b1;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              win_valid;
    logic              win_ready = 1'b1;
    logic [DATA_W-1:0] win_data;
    logic [5:0]        win_y, win_x;
    logic              win_ts, win_last, done;
    logic              all_ones = 1'b0;

    int vectors = 0, miscompares = 0;
    int cyc = 0, req_seen = 0, win_seen = 0, done_cnt = 0;
    int done_cyc = 0, cfg_cyc = 0, first_req_cyc = -1, last_cyc = 0;
    int outstanding = 0, job_n = 0;
    logic prev_stall = 1'b0;
    win_t prev_win, cur_win;
    logic [12:0] exp_addr_q[$];
    win_t        exp_win_q[$];

    ifmap_window_scanner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_conv_size(cfg_conv_size), .cfg_fil_size(cfg_fil_size),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_y(win_y), .win_x(win_x), .win_ts(win_ts), .win_last(win_last),
        .done(done)
    );

    function automatic logic [24:0] mem_word(input logic [12:0] a, input logic ones);
        return ones ? 25'h1FFFFFF : {a, ~a[11:0]};
    endfunction

    function automatic logic [24:0] mask_of(input logic [1:0] fil);
        case (fil)
            2'b00:   return 25'h000000F;
            2'b01:   return 25'h00001FF;
            2'b10:   return 25'h000FFFF;
            default: return 25'h1FFFFFF;
        endcase
    endfunction

    // Zero-latency memory: the response is returned in the same cycle the request is accepted.
    assign rsp_valid = req_valid && req_ready;
    assign rsp_data  = mem_word(req_addr, all_ones);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents a request, a window or done.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            cur_win = {win_data, win_y, win_x, win_ts, win_last};
            if (cfg_valid && cfg_ready) begin
                cfg_cyc = cyc;
                first_req_cyc = -1;
            end
            if (req_valid && first_req_cyc < 0) first_req_cyc = cyc;
            if (win_valid && prev_stall) chk("win_hold", cur_win, prev_win);
            if (req_valid && req_ready) begin
                chk("credit", 64'(outstanding < CAP), 64'd1);
                if (exp_addr_q.size() == 0) begin
                    chk("req_unexpected", 64'(req_addr), 64'h1FFF_FFFF);
                end else begin
                    chk("req_addr", 64'(req_addr), 64'(exp_addr_q.pop_front()));
                end
                req_seen++;
                outstanding++;
            end
            if (win_valid && win_ready) begin
                if (exp_win_q.size() == 0) begin
                    chk("win_unexpected", cur_win, 64'hFFFF_FFFF_FFFF);
                end else begin
                    chk("win", cur_win, exp_win_q.pop_front());
                end
                if (win_last) last_cyc = cyc;
                win_seen++;
                outstanding--;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (job_n != 0) chk("done_after_last", 64'(cyc), 64'(last_cyc + 1));
            end
            prev_stall = win_valid && !win_ready;
            prev_win   = cur_win;
        end
    end

    task automatic push_job(input int n, input logic [1:0] fil, input logic ones, input logic with_addr);
        for (int t = 0; t < 2; t++)
            for (int y = 0; y < n; y++)
                for (int x = 0; x < n; x++) begin
                    logic [12:0] a;
                    win_t w;
                    a = {6'(y), 6'(x), t[0]};
                    if (with_addr) exp_addr_q.push_back(a);
                    w.data = mem_word(a, ones) & mask_of(fil);
                    w.y = 6'(y);
                    w.x = 6'(x);
                    w.ts = t[0];
                    w.last = (t == 1) && (y == n - 1) && (x == n - 1);
                    exp_win_q.push_back(w);
                end
    endtask

    task automatic start_job(input int n, input logic [1:0] fil);
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_conv_size = 6'(n);
        cfg_fil_size = fil;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic run_job(input int n, input logic [1:0] fil, input logic ones, input logic with_addr);
        int d0, w0, k;
        all_ones = ones;
        job_n = n;
        push_job(n, fil, ones, with_addr);
        d0 = done_cnt;
        w0 = win_seen;
        start_job(n, fil);
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("win_count", 64'(win_seen - w0), 64'(2 * n * n));
        chk("exp_left", 64'(exp_win_q.size() + exp_addr_q.size()), 64'd0);
        chk("cfg_ready_back", 64'(cfg_ready), 64'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctrl"}, {cfg_ready, req_valid, rsp_ready, win_valid, win_last, done, win_ts}, 64'b1000000);
        chk({tag, "_addr"}, 64'(req_addr), 64'd0);
        chk({tag, "_win"}, {win_data, win_y, win_x}, 64'd0);
    endtask

    initial begin
        int r0, k;
        #12;
        check_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // N=2, 3x3 filter: hand-listed address order.
        exp_addr_q = '{13'h000, 13'h002, 13'h080, 13'h082, 13'h001, 13'h003, 13'h081, 13'h083};
        run_job(2, 2'b01, 1'b0, 1'b0);
        chk("req_rise", 64'(first_req_cyc), 64'(cfg_cyc + 1));

        // Masking extremes with an all-ones memory word.
        run_job(1, 2'b00, 1'b1, 1'b1);
        run_job(1, 2'b11, 1'b1, 1'b1);

        // N=3 with a 5-cycle stall on the 2nd window and a mid-job cfg attempt.
        win_ready = 1'b0;
        fork
            run_job(3, 2'b10, 1'b0, 1'b1);
            begin
                k = 0;
                while (!win_valid && k < 100) begin
                    @(posedge clk); #1;
                    k++;
                end
                win_ready = 1'b1;
                @(posedge clk); #1;
                win_ready = 1'b0;
                cfg_valid = 1'b1;
                cfg_conv_size = 6'd5;
                repeat (5) @(posedge clk);
                #1;
                cfg_valid = 1'b0;
                win_ready = 1'b1;
            end
        join

        // Empty job: no requests, done the cycle after the handshake.
        run_job(0, 2'b01, 1'b0, 1'b1);
        chk("n0_no_req", 64'(first_req_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("n0_done", 64'(done_cyc), 64'(cfg_cyc + 1));

`ifdef IFMAP_SCAN_PREFETCH_EN
        run_job(4, 2'b11, 1'b0, 1'b1);
        chk("prefetch_cycles", 64'((done_cyc - cfg_cyc) <= 36), 64'd1);
`endif

        // Reset after the 3rd request of an N=4 job, then a fresh N=1 job.
        all_ones = 1'b0;
        job_n = 4;
        push_job(4, 2'b01, 1'b0, 1'b1);
        r0 = req_seen;
        start_job(4, 2'b01);
        k = 0;
        while (req_seen < r0 + 3 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_reqs", 64'(req_seen - r0), 64'd3);
        check_reset("mid_reset");
        exp_addr_q.delete();
        exp_win_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset("held_reset");
        rst_n = 1'b1;
        exp_addr_q = '{13'h000, 13'h001};
        run_job(1, 2'b11, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
